// File: rtl/pifo_tree_arbiter.sv
// pifo_tree_arbiter: grants one push or pop per cycle from TREE_NUM logical trees onto a shared PIFO root.
// Optional macro PIFO_ARB_STRICT_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module pifo_tree_arbiter #(
  parameter int unsigned PTW      = 16,
  parameter int unsigned MTW      = 0,
  parameter int unsigned TREE_NUM = 4,
  parameter int unsigned TREE_CAP = 15,
  parameter int unsigned CNTW     = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [TREE_NUM-1:0]               i_req_push,
  input  logic [TREE_NUM-1:0]               i_req_pop,
  input  logic [TREE_NUM*(MTW+PTW)-1:0]     i_req_data,
  output logic [TREE_NUM-1:0]               o_req_ack,
  output logic                              o_rsp_valid,
  output logic [$clog2(TREE_NUM)-1:0]       o_rsp_tree_id,
  output logic [MTW+PTW-1:0]                o_rsp_data,
  output logic                              o_push,
  output logic                              o_pop,
  output logic [MTW+PTW-1:0]                o_push_data,
  input  logic [MTW+PTW-1:0]                i_pop_data,
  output logic [$clog2(TREE_NUM)-1:0]       o_tree_id,
  output logic [TREE_NUM-1:0]               o_empty,
  output logic [TREE_NUM-1:0]               o_full
);

  localparam int unsigned DW   = MTW + PTW;
  localparam int unsigned TIDW = $clog2(TREE_NUM);
  localparam logic [CNTW-1:0] CAP = CNTW'(TREE_CAP);

  typedef enum logic {S_ISSUE, S_POP_WAIT} state_t;

  state_t          r_state;
  logic [CNTW-1:0] r_cnt [TREE_NUM];
  logic [TIDW-1:0] r_ptr;
  logic [TIDW-1:0] r_pop_id;
  logic            r_rsp_valid;
  logic [TIDW-1:0] r_rsp_tree_id;
  logic [DW-1:0]   r_rsp_data;

  logic [DW-1:0]       w_data [TREE_NUM];
  logic [TREE_NUM-1:0] w_can_pop;
  logic [TREE_NUM-1:0] w_can_push;
  logic [TREE_NUM-1:0] w_elig;
  logic                w_gnt_vld;
  logic                w_gnt_pop;
  logic [TIDW-1:0]     w_gnt_id;

  // Per-tree request qualification against occupancy
  for (genvar g = 0; g < TREE_NUM; g++) begin : g_tree
    assign w_data[g]     = i_req_data[g*DW +: DW];
    assign w_can_pop[g]  = i_req_pop[g]  && (r_cnt[g] != '0);
    assign w_can_push[g] = i_req_push[g] && (r_cnt[g] != CAP);
    assign o_empty[g]    = (r_cnt[g] == '0);
    assign o_full[g]     = (r_cnt[g] == CAP);
  end

  assign w_elig = (w_can_pop | w_can_push) & {TREE_NUM{(r_state == S_ISSUE) && !i_rst}};

  // Search from r_ptr; descending loop leaves the nearest eligible tree as the winner
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int i = TREE_NUM - 1; i >= 0; i--) begin
      if (w_elig[TIDW'(r_ptr + TIDW'(i))]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = TIDW'(r_ptr + TIDW'(i));
      end
    end
  end

  assign w_gnt_pop     = w_can_pop[w_gnt_id];
  assign o_req_ack     = w_gnt_vld ? (TREE_NUM'(1) << w_gnt_id) : '0;
  assign o_push        = w_gnt_vld && !w_gnt_pop;
  assign o_pop         = w_gnt_vld && w_gnt_pop;
  assign o_tree_id     = w_gnt_vld ? w_gnt_id : '0;
  assign o_push_data   = o_push ? w_data[w_gnt_id] : '0;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_tree_id = r_rsp_tree_id;
  assign o_rsp_data    = r_rsp_data;

  // Issue / pop-wait sequencing, occupancy and response registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_ISSUE;
      r_ptr         <= '0;
      r_pop_id      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_tree_id <= '0;
      r_rsp_data    <= '0;
      for (int t = 0; t < TREE_NUM; t++) r_cnt[t] <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_ISSUE: begin
          if (w_gnt_vld) begin
`ifndef PIFO_ARB_STRICT_PRIO_EN
            r_ptr <= TIDW'(w_gnt_id + TIDW'(1));
`endif
            if (w_gnt_pop) begin
              r_cnt[w_gnt_id] <= r_cnt[w_gnt_id] - CNTW'(1);
              r_pop_id        <= w_gnt_id;
              r_state         <= S_POP_WAIT;
            end else begin
              r_cnt[w_gnt_id] <= r_cnt[w_gnt_id] + CNTW'(1);
            end
          end
        end
        S_POP_WAIT: begin
          r_rsp_valid   <= 1'b1;
          r_rsp_data    <= i_pop_data;
          r_rsp_tree_id <= r_pop_id;
          r_state       <= S_ISSUE;
        end
        default: r_state <= S_ISSUE;
      endcase
    end
  end

endmodule
